// File: rtl/conv_pkg.sv
// Shared types and default widths for the convolution accumulator.
package conv_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_ACC_W  = 40;
  localparam int unsigned DEF_OUT_W  = 32;
  localparam int unsigned DEF_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/acc_sat_narrow.sv
// Narrows the wide accumulator to the result width, clamping or wrapping,
// and flags when the sum did not fit the signed result range.
module acc_sat_narrow
  import conv_pkg::*;
#(
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned OUT_W    = DEF_OUT_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [ACC_W-1:0] i_sum,
  output logic [OUT_W-1:0] o_data,
  output logic             o_overflow
);

  // The sum fits iff every bit from the result sign bit upward is identical.
  logic [ACC_W-OUT_W:0] w_upper;
  logic                 w_neg;

  assign w_upper    = i_sum[ACC_W-1:OUT_W-1];
  assign w_neg      = i_sum[ACC_W-1];
  assign o_overflow = ~((&w_upper) | ~(|w_upper));

  // Clamp to the nearest bound when saturating, else keep the low bits.
  always_comb begin
    o_data = i_sum[OUT_W-1:0];
    if (SATURATE && o_overflow) begin
      o_data = w_neg ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conv_accumulator.sv
// Windowed signed accumulator: sums len products, then holds one result
// under valid/ready handshake until the consumer takes it.
//
//   state | meaning
//   IDLE  | no window open, waiting for the first beat
//   ACCUM | window open, partial sum in r_sum
//   HOLD  | result presented on o_out_data, waiting for o_out_ready
module conv_accumulator
  import conv_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned ACC_W    = DEF_ACC_W,
  parameter int unsigned OUT_W    = DEF_OUT_W,
  parameter int unsigned LEN_W    = DEF_LEN_W,
  parameter bit          SATURATE = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic [LEN_W-1:0]  i_accum_len,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [OUT_W-1:0]  o_out_data,
  output logic              o_out_overflow
);

  state_t             r_state;
  state_t             w_state_next;
  logic [ACC_W-1:0]   r_sum;
  logic [LEN_W-1:0]   r_count;
  logic [LEN_W-1:0]   r_len;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_ovf;

  logic               w_beat;
  logic               w_start;
  logic               w_last;
  logic               w_load;
  logic [LEN_W-1:0]   w_len_eff;
  logic [LEN_W-1:0]   w_count_inc;
  logic [ACC_W-1:0]   w_ext;
  logic [ACC_W-1:0]   w_sum_next;
  logic [OUT_W-1:0]   w_sat_data;
  logic               w_sat_ovf;

  assign w_beat      = i_in_valid & o_in_ready;
  // A beat outside ACCUM always opens a new window (HOLD only accepts when popping).
  assign w_start     = w_beat & (r_state != ACCUM);
  assign w_len_eff   = (i_accum_len == '0) ? LEN_W'(1) : i_accum_len;
  assign w_count_inc = r_count + LEN_W'(1);
  assign w_ext       = {{(ACC_W-DATA_W){i_in_data[DATA_W-1]}}, i_in_data};
  assign w_sum_next  = w_start ? w_ext : (r_sum + w_ext);
  assign w_last      = w_start ? (w_len_eff == LEN_W'(1)) : (w_count_inc == r_len);
  assign w_load      = w_beat & w_last & ~i_clear;

  acc_sat_narrow #(
    .ACC_W    (ACC_W),
    .OUT_W    (OUT_W),
    .SATURATE (SATURATE)
  ) u_sat (
    .i_sum      (w_sum_next),
    .o_data     (w_sat_data),
    .o_overflow (w_sat_ovf)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; clear overrides any beat or pop in the same cycle.
  always_comb begin
    w_state_next = r_state;
    if (i_clear) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_beat) w_state_next = w_last ? HOLD : ACCUM;
        end
        ACCUM: begin
          if (w_beat && w_last) w_state_next = HOLD;
        end
        HOLD: begin
          if (i_out_ready) begin
            if (w_beat) w_state_next = w_last ? HOLD : ACCUM;
            else        w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Handshake outputs; input side stays open during clear so the beat is swallowed.
  always_comb begin
    o_in_ready  = i_clear | (r_state != HOLD) | i_out_ready;
    o_out_valid = (r_state == HOLD);
  end

  // Sum, beat count, latched window length and the registered result.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sum      <= '0;
      r_count    <= '0;
      r_len      <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else if (i_clear) begin
      r_sum      <= '0;
      r_count    <= '0;
      r_out_data <= '0;
      r_out_ovf  <= 1'b0;
    end else begin
      if (w_beat) begin
        r_sum   <= w_sum_next;
        r_count <= w_start ? LEN_W'(1) : w_count_inc;
        if (w_start) r_len <= w_len_eff;
      end
      if (w_load) begin
        r_out_data <= w_sat_data;
        r_out_ovf  <= w_sat_ovf;
      end
    end
  end

  assign o_out_data     = r_out_data;
  assign o_out_overflow = r_out_ovf;

endmodule

// File: tb/tb_conv_accumulator.sv
// Bench for conv_accumulator: three instances (32-bit saturating, 16-bit
// saturating, 16-bit wrapping) share one stimulus stream and are compared
// against a window-level reference model using unbounded integer sums.
module tb_conv_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic [7:0]  accum_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        out_ready;

  logic        rdy_a, rdy_b, rdy_c;
  logic        val_a, val_b, val_c;
  logic [31:0] dat_a;
  logic [15:0] dat_b, dat_c;
  logic        ovf_a, ovf_b, ovf_c;

  int n_total;
  int n_pass;

  // reference model state
  bit     m_hold;
  bit     m_in_win;
  longint m_acc;
  longint m_res;
  int     m_cnt;
  int     m_len;

  conv_accumulator u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_accum_len(accum_len),
    .i_in_valid(in_valid), .o_in_ready(rdy_a), .i_in_data(in_data),
    .o_out_valid(val_a), .i_out_ready(out_ready), .o_out_data(dat_a),
    .o_out_overflow(ovf_a)
  );

  conv_accumulator #(.OUT_W(16), .SATURATE(1'b1)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_accum_len(accum_len),
    .i_in_valid(in_valid), .o_in_ready(rdy_b), .i_in_data(in_data),
    .o_out_valid(val_b), .i_out_ready(out_ready), .o_out_data(dat_b),
    .o_out_overflow(ovf_b)
  );

  conv_accumulator #(.OUT_W(16), .SATURATE(1'b0)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_accum_len(accum_len),
    .i_in_valid(in_valid), .o_in_ready(rdy_c), .i_in_data(in_data),
    .o_out_valid(val_c), .i_out_ready(out_ready), .o_out_data(dat_c),
    .o_out_overflow(ovf_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  function automatic longint f_max(int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint f_min(int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic bit f_ovf(longint s, int w);
    return (s > f_max(w)) || (s < f_min(w));
  endfunction

  function automatic longint f_clamp(longint s, int w);
    if (s > f_max(w)) return f_max(w);
    if (s < f_min(w)) return f_min(w);
    return s;
  endfunction

  task automatic model_reset();
    m_hold   = 1'b0;
    m_in_win = 1'b0;
    m_acc    = 0;
    m_cnt    = 0;
    m_len    = 1;
  endtask

  task automatic model_edge(input bit beat);
    if (clear) begin
      m_hold   = 1'b0;
      m_in_win = 1'b0;
    end else begin
      if (m_hold && out_ready) m_hold = 1'b0;
      if (beat) begin
        if (!m_in_win) begin
          m_in_win = 1'b1;
          m_acc    = 0;
          m_cnt    = 0;
          m_len    = (accum_len == 8'd0) ? 1 : int'(accum_len);
        end
        m_acc += longint'($signed(in_data));
        m_cnt++;
        if (m_cnt == m_len) begin
          m_hold   = 1'b1;
          m_res    = m_acc;
          m_in_win = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    longint      ca, cb;
    logic [31:0] ea;
    logic [15:0] eb, ec;
    chk("a_valid", 64'(val_a), 64'(m_hold));
    chk("b_valid", 64'(val_b), 64'(m_hold));
    chk("c_valid", 64'(val_c), 64'(m_hold));
    if (m_hold) begin
      ca = f_clamp(m_res, 32);
      cb = f_clamp(m_res, 16);
      ea = ca[31:0];
      eb = cb[15:0];
      ec = m_res[15:0];
      chk("a_data", 64'(dat_a), 64'(ea));
      chk("b_data", 64'(dat_b), 64'(eb));
      chk("c_data", 64'(dat_c), 64'(ec));
      chk("a_ovf", 64'(ovf_a), 64'(f_ovf(m_res, 32)));
      chk("b_ovf", 64'(ovf_b), 64'(f_ovf(m_res, 16)));
      chk("c_ovf", 64'(ovf_c), 64'(f_ovf(m_res, 16)));
    end
  endtask

  // One clock: check ready mid-cycle, advance the model on the edge, check outputs after.
  task automatic cycle();
    logic exp_rdy;
    bit   beat;
    @(negedge clk);
    exp_rdy = clear | ~m_hold | out_ready;
    chk("a_in_ready", 64'(rdy_a), 64'(exp_rdy));
    chk("b_in_ready", 64'(rdy_b), 64'(exp_rdy));
    chk("c_in_ready", 64'(rdy_c), 64'(exp_rdy));
    beat = in_valid & exp_rdy;
    @(posedge clk);
    model_edge(beat);
    #1;
    check_outputs();
  endtask

  task automatic drv(input logic v, input logic [15:0] d, input logic [7:0] l,
                     input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = d;
    accum_len = l;
    out_ready = ordy;
    clear     = clr;
    cycle();
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    accum_len = 8'd0;
    in_valid  = 1'b0;
    in_data   = 16'd0;
    out_ready = 1'b0;
    model_reset();

    #7;
    chk("rst_valid", 64'(val_a), 64'(0));
    chk("rst_data", 64'(dat_a), 64'(0));
    chk("rst_ovf", 64'(ovf_a), 64'(0));
    rst_n = 1'b1;

    // window of four, consumer always ready
    drv(1, 16'd1, 8'd4, 1, 0);
    drv(1, 16'd2, 8'd4, 1, 0);
    drv(1, 16'd3, 8'd4, 1, 0);
    drv(0, 16'd0, 8'd4, 1, 0);
    chk("t1_not_early", 64'(val_a), 64'(0));
    drv(1, 16'd4, 8'd4, 1, 0);
    chk("t1_valid", 64'(val_a), 64'(1));
    chk("t1_sum", 64'(dat_a), 64'(32'd10));
    chk("t1_ovf", 64'(ovf_a), 64'(0));
    drv(0, 16'd0, 8'd4, 1, 0);

    // back-to-back pairs with no bubble
    drv(1, -16'sd5, 8'd2, 1, 0);
    drv(1, 16'd3, 8'd2, 1, 0);
    chk("t2_first", 64'(dat_a), 64'(32'hFFFF_FFFE));
    drv(1, 16'd7, 8'd2, 1, 0);
    drv(1, 16'd7, 8'd2, 1, 0);
    chk("t2_second", 64'(dat_a), 64'(32'd14));
    drv(0, 16'd0, 8'd2, 1, 0);

    // overflow of the 16-bit result: clamp vs wrap
    drv(1, 16'd20000, 8'd3, 1, 0);
    drv(1, 16'd20000, 8'd3, 1, 0);
    drv(1, 16'd20000, 8'd3, 1, 0);
    chk("t3_sat16", 64'(dat_b), 64'(16'h7FFF));
    chk("t3_sat16_ovf", 64'(ovf_b), 64'(1));
    chk("t3_wrap16", 64'(dat_c), 64'(16'hEA60));
    chk("t3_wrap16_ovf", 64'(ovf_c), 64'(1));
    chk("t3_wide", 64'(dat_a), 64'(32'd60000));
    drv(0, 16'd0, 8'd3, 1, 0);

    // backpressure: result held five cycles, then pop together with a new beat
    drv(1, 16'd11, 8'd2, 0, 0);
    drv(1, 16'd22, 8'd2, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drv(1, 16'd99, 8'd2, 0, 0);
      chk("t4_stalled", 64'(rdy_a), 64'(0));
      chk("t4_held", 64'(dat_a), 64'(32'd33));
    end
    drv(1, 16'd5, 8'd2, 1, 0);
    chk("t4_popped", 64'(val_a), 64'(0));
    drv(1, 16'd6, 8'd2, 1, 0);
    chk("t4_next", 64'(dat_a), 64'(32'd11));
    drv(0, 16'd0, 8'd2, 1, 0);

    // clear mid-window (beat in that cycle discarded), then a fresh window
    drv(1, 16'd5, 8'd4, 1, 0);
    drv(1, 16'd5, 8'd4, 1, 0);
    drv(1, 16'd7, 8'd4, 1, 1);
    chk("t5_clear_valid", 64'(val_a), 64'(0));
    for (int i = 0; i < 4; i++) drv(1, 16'd1, 8'd4, 1, 0);
    chk("t5_after_clear", 64'(dat_a), 64'(32'd4));
    drv(0, 16'd0, 8'd4, 1, 0);
    drv(1, 16'd3, 8'd4, 1, 0);
    drv(1, 16'd3, 8'd4, 1, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(val_a), 64'(0));
    chk("t5_rst_data", 64'(dat_a), 64'(0));
    chk("t5_rst_ovf", 64'(ovf_b), 64'(0));
    chk("t5_rst_data16", 64'(dat_c), 64'(0));
    model_reset();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    drv(0, 16'd0, 8'd4, 1, 0);

    // zero length behaves as one; length change mid-window ignored
    drv(1, 16'd9, 8'd0, 1, 0);
    chk("t6_len0", 64'(dat_a), 64'(32'd9));
    chk("t6_len0_valid", 64'(val_a), 64'(1));
    drv(1, 16'd1, 8'd3, 1, 0);
    drv(1, 16'd1, 8'd1, 1, 0);
    chk("t6_len_latched", 64'(val_a), 64'(0));
    drv(1, 16'd1, 8'd1, 1, 0);
    chk("t6_sum3", 64'(dat_a), 64'(32'd3));
    drv(0, 16'd0, 8'd1, 1, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      drv(logic'($urandom_range(0, 3) != 0),
          16'($urandom),
          8'($urandom_range(0, 5)),
          logic'($urandom_range(0, 3) != 0),
          logic'($urandom_range(0, 40) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
